// File: rtl/joy_pkg.sv
// Shared constants, state type and frame helper for the DB15 joystick serial responder.
package joy_pkg;

   localparam int unsigned PLAYER_BITS = 12;
   localparam int unsigned FRAME_BITS  = 2 * PLAYER_BITS;
   localparam int unsigned COUNT_W     = 5;

   // Button positions within one player's word (bit 0 leaves the chain first)
   localparam int unsigned JOY_R = 0;
   localparam int unsigned JOY_L = 1;
   localparam int unsigned JOY_D = 2;
   localparam int unsigned JOY_U = 3;
   localparam int unsigned JOY_A = 4;
   localparam int unsigned JOY_B = 5;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } joy_state_t;

   // Parallel load image: buttons are active-low on the wire, player 1 in the low half.
   function automatic logic [FRAME_BITS-1:0] frame_word(input logic [PLAYER_BITS-1:0] p1,
                                                         input logic [PLAYER_BITS-1:0] p2);
      return ~{p2, p1};
   endfunction

endpackage

// File: rtl/joy_sync_edge.sv
// Two-flop synchronizer with rise/fall pulses; JOY_DB15_TX_FILTER_EN adds a
// 3-sample majority filter that rejects single-cycle glitches.
module joy_sync_edge
   import joy_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
      end
   end

`ifdef JOY_DB15_TX_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[0], sync_q};
         filt_q <= (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level;
      end
   end

   assign rise = level & ~prev_q;
   assign fall = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 shift-register joystick responder: answers JOY_LOAD/JOY_CLK with two players' buttons.
// Build option JOY_DB15_TX_FILTER_EN enables glitch filtering on both strobe inputs.
module joy_db15_tx
   import joy_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   joy_clk,
   input  logic                   joy_load,
   output logic                   joy_data,
   input  logic [PLAYER_BITS-1:0] joystick1,
   input  logic [PLAYER_BITS-1:0] joystick2,
   output logic [COUNT_W-1:0]     bit_count,
   output logic                   frame_done,
   output logic                   busy
);

   localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(FRAME_BITS - 1);

   logic ck_level, ck_rise, ck_fall;
   logic ld_level, ld_rise, ld_fall;

   joy_sync_edge u_sync_clk (
      .clk   (clk),
      .reset (reset),
      .din   (joy_clk),
      .level (ck_level),
      .rise  (ck_rise),
      .fall  (ck_fall)
   );

   joy_sync_edge u_sync_load (
      .clk   (clk),
      .reset (reset),
      .din   (joy_load),
      .level (ld_level),
      .rise  (ld_rise),
      .fall  (ld_fall)
   );

   // Load is level-sensitive, so the fall pulses and the clock level carry no extra information
   logic unused_edges;
   assign unused_edges = ^{ck_fall, ck_level, ld_fall};

   joy_state_t              state_q, state_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [COUNT_W-1:0]      count_q, count_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    data_q;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      count_d = count_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (!ld_level) begin
         // Transparent parallel load; also aborts any frame in progress
         state_d = LOAD;
         shreg_d = frame_word(joystick1, joystick2);
         count_d = '0;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               // A coincident clock edge is dropped in favour of the release
               if (ld_rise) begin
                  state_d = SHIFT;
                  busy_d  = 1'b1;
               end
            end
            SHIFT: begin
               if (ck_rise) begin
                  shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
                  count_d = count_q + COUNT_W'(1);
                  if (count_q == LAST_BIT) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               if (ck_rise) begin
                  shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
               end
            end
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         shreg_q <= '1;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         // Registered from the next-state value so the pin tracks the shift without a lag cycle
         data_q  <= shreg_d[0];
      end
   end

   assign joy_data   = data_q;
   assign bit_count  = count_q;
   assign frame_done = done_q;
   assign busy       = busy_q;

endmodule
